// File: rtl/esp_uart_pkg.sv
// Shared types and constants for the ESP serial transmit path.
//   uart_state_e : bit-level UART framing states (IDLE, SCAN, START, DATA, STOP)
//   word_state_e : word-level sequencing states used by uart_word_tx
//   clks_per_bit : integer-truncated clock count per UART bit
package esp_uart_pkg;

  localparam int unsigned BYTE_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    START,
    DATA,
    STOP
  } uart_state_e;

  // SEND covers the whole START/DATA/STOP run of every byte in the word.
  typedef enum logic [1:0] {
    W_IDLE,
    W_SCAN,
    W_LAUNCH,
    W_SEND
  } word_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte shifter: start bit, 8 data bits LSB first, one stop bit.
//   clk     : system clock, rising edge
//   rst     : asynchronous reset, active-low
//   start_i : byte_i is taken when idle, or on the final stop-bit clock
//             (the latter chains the next byte with no gap)
//   byte_i  : byte to send
//   done_o  : one-cycle pulse on the final clock of the stop bit
//   tx_o    : serial line, idle high, driven from a flop
module uart_byte_tx
  import esp_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [BYTE_BITS-1:0] byte_i,
  output logic                 done_o,
  output logic                 tx_o
);

  localparam int unsigned    CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e          st_q, st_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [BYTE_BITS-1:0] sh_q, sh_d;
  logic                 tx_q, tx_d;
  logic                 baud_last;

  assign baud_last = (baud_q == BAUD_LAST);
  assign tx_o      = tx_q;

  always_comb begin
    st_d   = st_q;
    baud_d = baud_last ? '0 : baud_q + CW'(1);
    bit_d  = bit_q;
    sh_d   = sh_q;
    done_o = 1'b0;
    unique case (st_q)
      IDLE: begin
        baud_d = '0;
        if (start_i) begin
          st_d  = START;
          sh_d  = byte_i;
          bit_d = '0;
        end
      end
      START: if (baud_last) st_d = DATA;
      DATA: begin
        if (baud_last) begin
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = STOP;
        end
      end
      STOP: begin
        if (baud_last) begin
          done_o = 1'b1;
          if (start_i) begin
            st_d  = START;
            sh_d  = byte_i;
            bit_d = '0;
          end else begin
            st_d = IDLE;
          end
        end
      end
      default: st_d = IDLE;
    endcase
    // Line level follows the state being entered so the flop output lines up
    // with state boundaries; transitions only happen on baud wrap, which also
    // clears the baud counter on every state entry.
    unique case (st_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= IDLE;
      baud_q <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      tx_q   <= 1'b1;
    end else begin
      st_q   <= st_d;
      baud_q <= baud_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      tx_q   <= tx_d;
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Serializes one word as 8N1 UART bytes, most-significant byte first,
// optionally dropping leading 0x00 bytes.
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active-low
//   tx_in_dat  : word to send (8*WORD_BYTES bits)
//   tx_in_val  : tx_in_dat valid
//   tx_out_rdy : word accepted on val & rdy at a rising edge
//   uart_tx    : serial line, idle high
//   busy       : high from accept until the final stop bit completes
module uart_word_tx
  import esp_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned WORD_BYTES = 16,
  parameter int unsigned SKIP_ZEROS = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BYTE_BITS*WORD_BYTES-1:0] tx_in_dat,
  input  logic                            tx_in_val,
  output logic                            tx_out_rdy,
  output logic                            uart_tx,
  output logic                            busy
);

  localparam int unsigned   CPB     = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned   WW      = BYTE_BITS * WORD_BYTES;
  localparam int unsigned   IW      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(WORD_BYTES - 1);

  word_state_e          st_q, st_d;
  logic [WW-1:0]        word_q, word_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        sel;
  logic                 start;
  logic                 done;
  logic                 word_zero;
  logic [BYTE_BITS-1:0] byte_sel;

  assign word_zero  = (word_q == '0);
  assign byte_sel   = word_q[sel*BYTE_BITS +: BYTE_BITS];
  assign tx_out_rdy = (st_q == W_IDLE);
  assign busy       = (st_q != W_IDLE);

  always_comb begin
    st_d   = st_q;
    word_d = word_q;
    idx_d  = idx_q;
    sel    = idx_q;
    start  = 1'b0;
    unique case (st_q)
      W_IDLE: begin
        if (tx_in_val) begin
          st_d   = W_SCAN;
          word_d = tx_in_dat;
          idx_d  = IDX_TOP;
        end
      end
      W_SCAN: begin
        // Ascending loop: the highest nonzero byte is the last assignment.
        if (SKIP_ZEROS != 0) begin
          for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            if (word_q[i*BYTE_BITS +: BYTE_BITS] != '0) idx_d = IW'(i);
          end
        end
        st_d = W_LAUNCH;
      end
      W_LAUNCH: begin
        if ((SKIP_ZEROS != 0) && word_zero) begin
          st_d = W_IDLE;
        end else begin
          start = 1'b1;
          st_d  = W_SEND;
        end
      end
      W_SEND: begin
        // The next byte is offered on the stop-bit's final clock so the
        // shifter chains straight into its start bit.
        if (done) begin
          if (idx_q == '0) begin
            st_d = W_IDLE;
          end else begin
            idx_d = idx_q - IW'(1);
            sel   = idx_q - IW'(1);
            start = 1'b1;
          end
        end
      end
      default: st_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= W_IDLE;
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      st_q   <= st_d;
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CPB)
  ) u_byte_tx (
    .clk    (clk),
    .rst    (rst),
    .start_i(start),
    .byte_i (byte_sel),
    .done_o (done),
    .tx_o   (uart_tx)
  );

endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;

  localparam int unsigned CF  = 1_000_000;
  localparam int unsigned BR  = 100_000;
  localparam int unsigned WB  = 16;
  localparam int          CPB = 10;

  typedef bit bitq_t[$];

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] dat0, dat1;
  logic         val0, val1;
  logic         rdy0, rdy1, tx0, tx1, busy0, busy1;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // DUT 0 drops leading zeros, DUT 1 always sends the full word.
  uart_word_tx #(.CLK_FREQ(CF), .BAUD(BR), .WORD_BYTES(WB), .SKIP_ZEROS(1)) u_dut0 (
    .clk(clk), .rst(rst), .tx_in_dat(dat0), .tx_in_val(val0),
    .tx_out_rdy(rdy0), .uart_tx(tx0), .busy(busy0));

  uart_word_tx #(.CLK_FREQ(CF), .BAUD(BR), .WORD_BYTES(WB), .SKIP_ZEROS(0)) u_dut1 (
    .clk(clk), .rst(rst), .tx_in_dat(dat1), .tx_in_val(val1),
    .tx_out_rdy(rdy1), .uart_tx(tx1), .busy(busy1));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic v, input logic [127:0] d);
    if (which == 0) begin val0 = v; dat0 = d; end
    else            begin val1 = v; dat1 = d; end
  endtask

  task automatic sample(input int which, output logic t, output logic b, output logic r);
    if (which == 0) begin t = tx0; b = busy0; r = rdy0; end
    else            begin t = tx1; b = busy1; r = rdy1; end
  endtask

  // Expected serial bit sequence: per byte, start 0, data LSB first, stop 1.
  function automatic bitq_t frame_bits(input logic [127:0] w, input bit skip);
    bitq_t q;
    int first = 15;
    if (skip) begin
      first = -1;
      for (int b = 15; b >= 0; b--) begin
        if (w[8*b +: 8] != 8'h00) begin first = b; break; end
      end
    end
    for (int b = first; b >= 0; b--) begin
      q.push_back(1'b0);
      for (int k = 0; k < 8; k++) q.push_back(w[8*b + k]);
      q.push_back(1'b1);
    end
    return q;
  endfunction

  function automatic logic [127:0] rand_word();
    logic [127:0] w = {$urandom, $urandom, $urandom, $urandom};
    int lead = $urandom_range(0, 16);
    for (int b = 0; b < 16; b++) begin
      if (b >= 16 - lead) w[8*b +: 8] = 8'h00;
      else if ($urandom_range(0, 3) == 0) w[8*b +: 8] = 8'h00;
    end
    return w;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic offer(input int which, input logic [127:0] w);
    logic t, b, r;
    sample(which, t, b, r);
    chk($sformatf("d%0d rdy_before_offer", which), r, 1'b1);
    drive(which, 1'b1, w);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks line/busy/rdy each cycle from the accept (j=0) to the first idle cycle (j=L).
  // stop_at >= 0 ends the check early at the negedge of cycle stop_at.
  task automatic expect_word(input int which, input logic [127:0] w, input bit keep_val,
                             input logic [127:0] next_w, input int stop_at);
    bitq_t bits = frame_bits(w, which == 0);
    int    L    = 2 + CPB * bits.size();
    int    last = (stop_at >= 0) ? stop_at - 1 : L;
    logic  t, b, r, exp_line;
    if (keep_val) drive(which, 1'b1, next_w);
    else          drive(which, 1'b0, {$urandom, $urandom, $urandom, $urandom});
    for (int j = 0; j <= last; j++) begin
      if (j > 0) @(negedge clk);
      // Input noise while busy must not disturb the latched word.
      if (!keep_val && j > 0 && j < L && (j % 7) == 0)
        drive(which, 1'b0, {$urandom, $urandom, $urandom, $urandom});
      exp_line = (j < 2 || j >= L) ? 1'b1 : bits[(j - 2) / CPB];
      sample(which, t, b, r);
      chk($sformatf("d%0d line j=%0d", which, j), t, exp_line);
      chk($sformatf("d%0d busy j=%0d", which, j), b, (j < L));
      chk($sformatf("d%0d rdy j=%0d", which, j), r, (j >= L));
    end
    if (stop_at >= 0) @(negedge clk);
  endtask

  task automatic send(input int which, input logic [127:0] w);
    offer(which, w);
    expect_word(which, w, 1'b0, '0, -1);
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] w1, w2, msg;
    rst = 1'b0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    repeat (3) @(negedge clk);
    chk("reset tx0", tx0, 1'b1);
    chk("reset busy0", busy0, 1'b0);
    chk("reset tx1", tx1, 1'b1);
    chk("reset busy1", busy1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset rdy0", rdy0, 1'b1);
    chk("post_reset rdy1", rdy1, 1'b1);

    msg = 128'h0000_0000_0000_7465_7374_7465_7374_5C6E;
    send(0, msg);                          // 10 bytes, busy for 1002 cycles
    send(1, msg);                          // 16 bytes including six 0x00
    send(0, '0);                           // no line activity, 2-cycle busy
    send(0, 128'h0100_0000_0000_0000_0000_0000_0000_0002);
    send(1, '0);                           // full-length zero frames

    // Back-to-back with val held: second word accepted on the first idle cycle.
    w1 = rand_word();
    w1[127:120] = 8'h3C;
    w2 = rand_word();
    offer(0, w1);
    expect_word(0, w1, 1'b1, w2, -1);
    @(posedge clk);
    @(negedge clk);
    expect_word(0, w2, 1'b0, '0, -1);
    @(negedge clk);

    for (int t = 0; t < 4; t++) begin
      send(0, rand_word());
      send(1, rand_word());
    end

    // Reset in the middle of the third byte's data bits.
    w1 = rand_word();
    w1[127:120] = 8'hA5;
    w1[111:104] = 8'hC3;
    offer(0, w1);
    expect_word(0, w1, 1'b0, '0, 2 + 2*CPB*10 + CPB + 35);
    rst = 1'b0;
    #1;
    chk("abort tx0", tx0, 1'b1);
    chk("abort busy0", busy0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      chk($sformatf("after_abort tx0 j=%0d", j), tx0, 1'b1);
      chk($sformatf("after_abort busy0 j=%0d", j), busy0, 1'b0);
      chk($sformatf("after_abort rdy0 j=%0d", j), rdy0, 1'b1);
    end
    send(0, rand_word());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
